// File: rtl/dilithium_op_sequencer_if.sv
// Host and core stream bundle for the Dilithium operation sequencer.
// The sequencer sits on the master side; the host/core environment uses the slave side.
interface dilithium_op_sequencer_if #(
  parameter int W = 64
);
  logic         valid_i;
  logic         ready_i;
  logic [W-1:0] data_i;
  logic         valid_o;
  logic         ready_o;
  logic [W-1:0] data_o;
  logic         core_valid_i;
  logic         core_ready_i;
  logic [W-1:0] core_data_i;
  logic         core_valid_o;
  logic         core_ready_o;
  logic [W-1:0] core_data_o;

  modport master (
    input  valid_i, data_i, ready_o, core_ready_i, core_valid_o, core_data_o,
    output ready_i, valid_o, data_o, core_valid_i, core_data_i, core_ready_o
  );

  modport slave (
    output valid_i, data_i, ready_o, core_ready_i, core_valid_o, core_data_o,
    input  ready_i, valid_o, data_o, core_valid_i, core_data_i, core_ready_o
  );
endinterface

// File: rtl/dilithium_op_sequencer.sv
// Control wrapper around a Dilithium core: validates and launches operations,
// gates the host/core streams while running, and keeps status, watchdog and counters.
module dilithium_op_sequencer #(
  parameter int W       = 64,
  parameter int REJ_W   = 8,
  parameter int CYC_W   = 32,
  parameter int BEAT_W  = 16,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [2:0]        sec_lvl,
  output logic              done,
  output logic              busy,
  output logic              error,
  output logic              core_start,
  output logic [1:0]        core_mode,
  output logic [2:0]        core_sec_lvl,
  output logic              core_abort,
  input  logic              core_done,
  input  logic              core_sign_reject,
  output logic [REJ_W-1:0]  reject_counter,
  output logic [CYC_W-1:0]  cycle_counter,
  output logic [BEAT_W-1:0] beats_in,
  output logic [BEAT_W-1:0] beats_out,
  dilithium_op_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_ABORT = 2'd2,
    S_FIN   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               start_q;
  logic               rej_q;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               core_start_q, core_start_d;
  logic [1:0]         mode_q, mode_d;
  logic [2:0]         sec_q, sec_d;
  logic [REJ_W-1:0]   rej_cnt_q, rej_cnt_d;
  logic [CYC_W-1:0]   cyc_cnt_q, cyc_cnt_d;
  logic [BEAT_W-1:0]  bin_q, bin_d;
  logic [BEAT_W-1:0]  bout_q, bout_d;

  logic strobe;
  logic req_legal;
  logic rej_rise;
  logic run;
  logic timeout_hit;

  assign strobe    = start & ~start_q;
  assign rej_rise  = core_sign_reject & ~rej_q;
  assign run       = (state_q == S_RUN);
  assign req_legal = (mode != 2'd3) &&
                     ((sec_lvl == 3'd2) || (sec_lvl == 3'd3) || (sec_lvl == 3'd5));

  // Counter reads k-1 during the k-th RUN cycle, so the abort lands on RUN cycle TIMEOUT+1.
  generate
    if (TIMEOUT > 0) begin : g_wd
      assign timeout_hit = (cyc_cnt_q == CYC_W'(TIMEOUT - 1));
    end else begin : g_no_wd
      assign timeout_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    done_d       = done_q;
    error_d      = error_q;
    core_start_d = 1'b0;
    mode_d       = mode_q;
    sec_d        = sec_q;
    rej_cnt_d    = rej_cnt_q;
    cyc_cnt_d    = cyc_cnt_q;
    bin_d        = bin_q;
    bout_d       = bout_q;
    unique case (state_q)
      S_IDLE, S_FIN: begin
        if (strobe) begin
          done_d    = 1'b0;
          error_d   = 1'b0;
          rej_cnt_d = '0;
          cyc_cnt_d = '0;
          bin_d     = '0;
          bout_d    = '0;
          mode_d    = mode;
          sec_d     = sec_lvl;
          if (req_legal) begin
            state_d      = S_RUN;
            core_start_d = 1'b1;
          end else begin
            state_d = S_FIN;
            done_d  = 1'b1;
            error_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (~&cyc_cnt_q) cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
        if (rej_rise && ~&rej_cnt_q) rej_cnt_d = rej_cnt_q + REJ_W'(1);
        if (bus.valid_i && bus.core_ready_i && ~&bin_q) bin_d = bin_q + BEAT_W'(1);
        if (bus.core_valid_o && bus.ready_o && ~&bout_q) bout_d = bout_q + BEAT_W'(1);
        // Completion takes priority over a watchdog expiry in the same cycle.
        if (core_done) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end else if (timeout_hit) begin
          state_d = S_ABORT;
          done_d  = 1'b1;
          error_d = 1'b1;
        end
      end
      S_ABORT: state_d = S_FIN;
      default: state_d = S_IDLE;
    endcase
  end

  // start_q resets high so a start held through reset is not seen as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b1;
      rej_q        <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      core_start_q <= 1'b0;
      mode_q       <= 2'd0;
      sec_q        <= 3'd0;
      rej_cnt_q    <= '0;
      cyc_cnt_q    <= '0;
      bin_q        <= '0;
      bout_q       <= '0;
    end else begin
      state_q      <= state_d;
      start_q      <= start;
      rej_q        <= core_sign_reject;
      done_q       <= done_d;
      error_q      <= error_d;
      core_start_q <= core_start_d;
      mode_q       <= mode_d;
      sec_q        <= sec_d;
      rej_cnt_q    <= rej_cnt_d;
      cyc_cnt_q    <= cyc_cnt_d;
      bin_q        <= bin_d;
      bout_q       <= bout_d;
    end
  end

  assign done           = done_q;
  assign error          = error_q;
  assign busy           = (state_q == S_RUN) || (state_q == S_ABORT);
  assign core_start     = core_start_q;
  assign core_abort     = (state_q == S_ABORT);
  assign core_mode      = mode_q;
  assign core_sec_lvl   = sec_q;
  assign reject_counter = rej_cnt_q;
  assign cycle_counter  = cyc_cnt_q;
  assign beats_in       = bin_q;
  assign beats_out      = bout_q;

  // Streams only move in RUN; data is zeroed otherwise so nothing leaks between operations.
  assign bus.core_valid_i = run & bus.valid_i;
  assign bus.ready_i      = run & bus.core_ready_i;
  assign bus.core_data_i  = run ? bus.data_i : {W{1'b0}};
  assign bus.valid_o      = run & bus.core_valid_o;
  assign bus.core_ready_o = run & bus.ready_o;
  assign bus.data_o       = run ? bus.core_data_o : {W{1'b0}};

endmodule

// File: tb/tb_dilithium_op_sequencer.sv
// Bench for dilithium_op_sequencer: a default instance (no watchdog) and a watchdog
// instance (TIMEOUT=50, REJ_W=2) share stimulus and are checked against an operation-level model.
`timescale 1ns/1ps
module tb_dilithium_op_sequencer;
  localparam int W    = 64;
  localparam int TO   = 50;
  localparam int MAXK = 256;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   mode;
  logic [2:0]   sec_lvl;
  logic         core_done, core_sign_reject;
  logic         valid_i, core_ready_i, core_valid_o, ready_o;
  logic [W-1:0] data_i, core_data_o;

  logic         done_m, busy_m, error_m, core_start_m, core_abort_m;
  logic [1:0]   core_mode_m;
  logic [2:0]   core_sec_m;
  logic [7:0]   rej_m;
  logic [31:0]  cyc_m;
  logic [15:0]  bin_m, bout_m;

  logic         done_w, busy_w, error_w, core_start_w, core_abort_w;
  logic [1:0]   core_mode_w;
  logic [2:0]   core_sec_w;
  logic [1:0]   rej_w;
  logic [31:0]  cyc_w;
  logic [15:0]  bin_w, bout_w;

  dilithium_op_sequencer_if #(.W(W)) bus_m ();
  dilithium_op_sequencer_if #(.W(W)) bus_w ();

  assign bus_m.valid_i      = valid_i;
  assign bus_m.data_i       = data_i;
  assign bus_m.ready_o      = ready_o;
  assign bus_m.core_ready_i = core_ready_i;
  assign bus_m.core_valid_o = core_valid_o;
  assign bus_m.core_data_o  = core_data_o;
  assign bus_w.valid_i      = valid_i;
  assign bus_w.data_i       = data_i;
  assign bus_w.ready_o      = ready_o;
  assign bus_w.core_ready_i = core_ready_i;
  assign bus_w.core_valid_o = core_valid_o;
  assign bus_w.core_data_o  = core_data_o;

  dilithium_op_sequencer #(.W(W)) dut_m (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .sec_lvl(sec_lvl),
    .done(done_m), .busy(busy_m), .error(error_m),
    .core_start(core_start_m), .core_mode(core_mode_m), .core_sec_lvl(core_sec_m),
    .core_abort(core_abort_m), .core_done(core_done), .core_sign_reject(core_sign_reject),
    .reject_counter(rej_m), .cycle_counter(cyc_m), .beats_in(bin_m), .beats_out(bout_m),
    .bus(bus_m)
  );

  dilithium_op_sequencer #(.W(W), .REJ_W(2), .TIMEOUT(TO)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .sec_lvl(sec_lvl),
    .done(done_w), .busy(busy_w), .error(error_w),
    .core_start(core_start_w), .core_mode(core_mode_w), .core_sec_lvl(core_sec_w),
    .core_abort(core_abort_w), .core_done(core_done), .core_sign_reject(core_sign_reject),
    .reject_counter(rej_w), .cycle_counter(cyc_w), .beats_in(bin_w), .beats_out(bout_w),
    .bus(bus_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit err_m; bit err_w;
    int cyc_m; int cyc_w;
    int rej_m; int rej_w;
    int bi_m;  int bo_m;
    int bi_w;  int bo_w;
  } exp_t;

  typedef struct {
    logic [1:0] mode; logic [2:0] sec; int d; int n_rej; int n_hs;
    bit err_m; bit err_w; int cyc_m; int cyc_w; int rej_m; int rej_w; int bt_m; int bt_w;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int op_no  = 0;

  logic         stim_vi  [0:MAXK-1];
  logic         stim_cri [0:MAXK-1];
  logic         stim_cvo [0:MAXK-1];
  logic         stim_ro  [0:MAXK-1];
  logic         stim_rej [0:MAXK-1];
  logic [W-1:0] stim_di  [0:MAXK-1];
  logic [W-1:0] stim_cdo [0:MAXK-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic bit is_legal(input logic [1:0] m, input logic [2:0] s);
    return (m != 2'd3) && (s == 3'd2 || s == 3'd3 || s == 3'd5);
  endfunction

  // Operation-level model: how long each instance stays in RUN, then count events in that window.
  function automatic exp_t model(input logic [1:0] m, input logic [2:0] s, input int d);
    exp_t e;
    bit   lg;
    int   len_m, len_w, r_m, r_w;
    lg    = is_legal(m, s);
    len_m = lg ? d : 0;
    len_w = lg ? ((d < TO) ? d : TO) : 0;
    e.err_m = !lg;
    e.err_w = !lg || (d > TO);
    e.cyc_m = len_m;
    e.cyc_w = len_w;
    r_m = 0; r_w = 0;
    e.bi_m = 0; e.bo_m = 0; e.bi_w = 0; e.bo_w = 0;
    for (int k = 1; k <= len_m; k++) begin
      if (stim_rej[k] && !stim_rej[k-1]) begin
        r_m++;
        if (k <= len_w) r_w++;
      end
      if (stim_vi[k] && stim_cri[k]) begin
        e.bi_m++;
        if (k <= len_w) e.bi_w++;
      end
      if (stim_cvo[k] && stim_ro[k]) begin
        e.bo_m++;
        if (k <= len_w) e.bo_w++;
      end
    end
    e.rej_m = (r_m > 255) ? 255 : r_m;
    e.rej_w = (r_w > 3) ? 3 : r_w;
    return e;
  endfunction

  task automatic fill_random();
    for (int k = 0; k < MAXK; k++) begin
      stim_vi[k]  = 1'($urandom_range(0, 1));
      stim_cri[k] = 1'($urandom_range(0, 1));
      stim_cvo[k] = 1'($urandom_range(0, 1));
      stim_ro[k]  = 1'($urandom_range(0, 1));
      stim_rej[k] = ($urandom_range(0, 5) == 0);
      stim_di[k]  = {$urandom, $urandom};
      stim_cdo[k] = {$urandom, $urandom};
    end
    stim_rej[0] = 1'b0;
  endtask

  // Reject pulses 3 cycles wide starting at 10, 20, ...; handshakes on alternating cycles.
  task automatic fill_pattern(input int n_rej, input int n_hs);
    for (int k = 0; k < MAXK; k++) begin
      stim_vi[k]  = (k <= 2 * n_hs);
      stim_cri[k] = k[0];
      stim_cvo[k] = ~k[0];
      stim_ro[k]  = (k <= 2 * n_hs);
      stim_rej[k] = 1'b0;
      stim_di[k]  = {$urandom, $urandom};
      stim_cdo[k] = {$urandom, $urandom};
    end
    for (int i = 1; i <= n_rej; i++)
      for (int j = 0; j < 3; j++) stim_rej[10 * i + j] = 1'b1;
  endtask

  // Per-cycle status/gating check; k is the cycle index after the accepting edge (0 = before).
  task automatic cycle_check(input int k, input bit lg, input int d);
    bit run_m, run_w, ab_w;
    int lim_w;
    logic [7:0] a_m, e_m, a_w, e_w;
    lim_w = (d < TO) ? d : TO;
    run_m = lg && k >= 1 && k <= d;
    run_w = lg && k >= 1 && k <= lim_w;
    ab_w  = lg && d > TO && k == TO + 1;
    e_m = {run_m, lg && k == 1, 1'b0, run_m & core_ready_i, run_m & valid_i,
           run_m & core_valid_o, run_m & ready_o, 1'b1};
    a_m = {busy_m, core_start_m, core_abort_m, bus_m.ready_i, bus_m.core_valid_i,
           bus_m.valid_o, bus_m.core_ready_o,
           run_m ? (bus_m.core_data_i == data_i && bus_m.data_o == core_data_o) : 1'b1};
    e_w = {run_w | ab_w, lg && k == 1, ab_w, run_w & core_ready_i, run_w & valid_i,
           run_w & core_valid_o, run_w & ready_o, 1'b1};
    a_w = {busy_w, core_start_w, core_abort_w, bus_w.ready_i, bus_w.core_valid_i,
           bus_w.valid_o, bus_w.core_ready_o,
           run_w ? (bus_w.core_data_i == data_i && bus_w.data_o == core_data_o) : 1'b1};
    chk($sformatf("stat_main_k%0d", k), 64'(a_m), 64'(e_m));
    chk($sformatf("stat_wd_k%0d", k), 64'(a_w), 64'(e_w));
  endtask

  task automatic run_op(input logic [1:0] m, input logic [2:0] s, input int d, input exp_t e);
    bit lg;
    lg = is_legal(m, s);
    @(negedge clk);
    start = 1'b0; core_done = 1'b0; core_sign_reject = 1'b0;
    valid_i = 1'b1; core_ready_i = 1'b1; core_valid_o = 1'b1; ready_o = 1'b1;
    data_i = {$urandom, $urandom}; core_data_o = {$urandom, $urandom};
    #1 cycle_check(0, 1'b0, 0);
    @(negedge clk);
    start = 1'b1; mode = m; sec_lvl = s;
    #1 cycle_check(0, 1'b0, 0);
    for (int k = 1; k <= d + 3; k++) begin
      @(negedge clk);
      valid_i = stim_vi[k]; core_ready_i = stim_cri[k];
      core_valid_o = stim_cvo[k]; ready_o = stim_ro[k];
      data_i = stim_di[k]; core_data_o = stim_cdo[k];
      core_sign_reject = stim_rej[k];
      core_done = (k == d);
      // A second start edge mid-run must be ignored.
      if (lg && d >= 8) begin
        if (k == 3) start = 1'b0;
        if (k == 6) start = 1'b1;
      end
      #1;
      if (k == 1) begin
        chk("clear_main", {done_m, error_m, 8'(rej_m), cyc_m, bin_m, bout_m},
            {!lg, !lg, 8'd0, 32'd0, 16'd0, 16'd0});
        chk("clear_wd", {done_w, error_w, 8'(rej_w), cyc_w, bin_w, bout_w},
            {!lg, !lg, 8'd0, 32'd0, 16'd0, 16'd0});
      end
      cycle_check(k, lg, d);
    end
    chk("done_main", 64'(done_m), 64'd1);
    chk("done_wd", 64'(done_w), 64'd1);
    chk("error_main", 64'(error_m), 64'(e.err_m));
    chk("error_wd", 64'(error_w), 64'(e.err_w));
    chk("cycles_main", 64'(cyc_m), 64'(e.cyc_m));
    chk("cycles_wd", 64'(cyc_w), 64'(e.cyc_w));
    chk("rejects_main", 64'(rej_m), 64'(e.rej_m));
    chk("rejects_wd", 64'(rej_w), 64'(e.rej_w));
    chk("beats_in_main", 64'(bin_m), 64'(e.bi_m));
    chk("beats_out_main", 64'(bout_m), 64'(e.bo_m));
    chk("beats_in_wd", 64'(bin_w), 64'(e.bi_w));
    chk("beats_out_wd", 64'(bout_w), 64'(e.bo_w));
    chk("latched_op_main", {core_mode_m, core_sec_m}, {m, s});
    chk("latched_op_wd", {core_mode_w, core_sec_w}, {m, s});
    $display("op %0d mode=%0d sec=%0d d=%0d legal=%0b err=%0b/%0b cyc=%0d/%0d rej=%0d/%0d beats=%0d/%0d",
             op_no, m, s, d, lg, error_m, error_w, cyc_m, cyc_w, rej_m, rej_w, bin_m, bin_w);
    op_no++;
  endtask

  vec_t tbl [0:8];

  initial begin
    exp_t e;
    logic [1:0] rm;
    logic [2:0] rs;
    int rd;

    tbl[0] = '{2'd1, 3'd2, 200, 3, 10, 1'b0, 1'b1, 200, 50, 3, 3, 10, 10};
    tbl[1] = '{2'd3, 3'd2,  20, 0,  0, 1'b1, 1'b1,   0,  0, 0, 0,  0,  0};
    tbl[2] = '{2'd0, 3'd4,  20, 0,  0, 1'b1, 1'b1,   0,  0, 0, 0,  0,  0};
    tbl[3] = '{2'd2, 3'd5,  50, 2,  5, 1'b0, 1'b0,  50, 50, 2, 2,  5,  5};
    tbl[4] = '{2'd0, 3'd3,  51, 5, 20, 1'b0, 1'b1,  51, 50, 5, 3, 20, 20};
    tbl[5] = '{2'd1, 3'd5,  49, 4,  0, 1'b0, 1'b0,  49, 49, 4, 3,  0,  0};
    tbl[6] = '{2'd2, 3'd0,  10, 0,  0, 1'b1, 1'b1,   0,  0, 0, 0,  0,  0};
    tbl[7] = '{2'd1, 3'd3,   1, 0,  0, 1'b0, 1'b0,   1,  1, 0, 0,  0,  0};
    tbl[8] = '{2'd0, 3'd2, 100, 1,  3, 1'b0, 1'b1, 100, 50, 1, 1,  3,  3};

    rst_n = 1'b0; start = 1'b1; mode = 2'd0; sec_lvl = 3'd0;
    core_done = 1'b0; core_sign_reject = 1'b0;
    valid_i = 1'b1; core_ready_i = 1'b1; core_valid_o = 1'b1; ready_o = 1'b1;
    data_i = '0; core_data_o = '0;

    repeat (3) @(negedge clk);
    chk("reset_main", {done_m, busy_m, error_m, core_start_m, core_abort_m, core_mode_m,
                       core_sec_m, 8'(rej_m), cyc_m, bin_m, bout_m}, 64'd0);
    chk("reset_wd", {done_w, busy_w, error_w, core_start_w, core_abort_w, core_mode_w,
                     core_sec_w, 8'(rej_w), cyc_w, bin_w, bout_w}, 64'd0);

    // Start held high across reset release must not launch anything; streams stay gated.
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1 cycle_check(0, 1'b0, 0);
      chk("idle_status", {done_m, done_w, error_m, error_w, bin_m, bin_w}, 64'd0);
    end

    for (int i = 0; i < 9; i++) begin
      fill_pattern(tbl[i].n_rej, tbl[i].n_hs);
      e.err_m = tbl[i].err_m; e.err_w = tbl[i].err_w;
      e.cyc_m = tbl[i].cyc_m; e.cyc_w = tbl[i].cyc_w;
      e.rej_m = tbl[i].rej_m; e.rej_w = tbl[i].rej_w;
      e.bi_m = tbl[i].bt_m; e.bo_m = tbl[i].bt_m;
      e.bi_w = tbl[i].bt_w; e.bo_w = tbl[i].bt_w;
      run_op(tbl[i].mode, tbl[i].sec, tbl[i].d, e);
    end

    for (int i = 0; i < 12; i++) begin
      fill_random();
      rm = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: rs = 3'd2;
        1: rs = 3'd3;
        2: rs = 3'd5;
        default: rs = 3'($urandom_range(0, 7));
      endcase
      rd = $urandom_range(1, 120);
      run_op(rm, rs, rd, model(rm, rs, rd));
    end

    // Asynchronous reset in the middle of a run: back to idle at once, no abort pulse.
    @(negedge clk);
    start = 1'b0; core_done = 1'b0; core_sign_reject = 1'b0;
    @(negedge clk);
    start = 1'b1; mode = 2'd1; sec_lvl = 3'd2;
    repeat (10) @(negedge clk);
    chk("midrun_busy", {busy_m, busy_w}, 64'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_main", {busy_m, done_m, core_abort_m, core_start_m, cyc_m}, 64'd0);
    chk("midreset_wd", {busy_w, done_w, core_abort_w, core_start_w, cyc_w}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1 cycle_check(0, 1'b0, 0);
    end
    $display("op %0d mid-run reset busy=%0b/%0b", op_no, busy_m, busy_w);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
